// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider and the pulse period meter.
// Both blocks use the same default counter width so that readouts line up.
package clk_div_pkg;

  localparam int DIV_COUNTER_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/pulse_period_meter_sync.sv
// Synchronizer followed by a registered rising-edge detector.
// The output is a one-cycle pulse that arrives STAGES+1 cycles after the input rises.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic edge_o
);

  logic s;
  logic s_d;

  if (STAGES > 0) begin : g_sync
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= sig_i;
        for (int i = 1; i < STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[STAGES-1];
  end else begin : g_bypass
    assign s = sig_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_d    <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      s_d    <= s;
      edge_o <= s & ~s_d;
    end
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the rising-edge to rising-edge period of sig_i in clk cycles and
// reports the truncated average of 2**AVG_LOG2 consecutive periods.
//
// state   | meaning
// IDLE    | waiting for start_i
// ARM     | waiting for the first rising edge that opens a window
// MEASURE | counting cycles between edges, accumulating samples
module pulse_period_meter
  import clk_div_pkg::*;
#(
  parameter int                       COUNTER_WIDTH = DIV_COUNTER_WIDTH,
  parameter int                       AVG_LOG2      = 2,
  parameter int                       SYNC_STAGES   = 2,
  parameter logic [COUNTER_WIDTH-1:0] MAX_PERIOD    = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sig_i,
  input  logic                     start_i,
  input  logic                     cont_i,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic                     valid_o,
  output logic                     timeout_o,
  output logic                     busy_o
);

  localparam int ACC_W = COUNTER_WIDTH + AVG_LOG2;
  localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  meter_state_t state;
  meter_state_t state_nx;

  logic [COUNTER_WIDTH-1:0] cnt;
  logic [ACC_W-1:0]         acc;
  logic [N_W-1:0]           n;
  logic [ACC_W-1:0]         sum;

  logic edge_det;
  logic cnt_max;
  logic last_sample;

  logic arm_start;
  logic win_open;
  logic sample_take;
  logic cnt_inc;
  logic done;
  logic tmo;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sig_i),
    .edge_o (edge_det)
  );

  assign cnt_max     = (cnt == MAX_PERIOD);
  assign last_sample = (n == N_LAST);
  assign sum         = acc + ACC_W'(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_i) state_nx = ARM;
      end
      ARM: begin
        if (edge_det)     state_nx = MEASURE;
        else if (cnt_max) state_nx = IDLE;
      end
      MEASURE: begin
        if (edge_det) begin
          if (last_sample && !cont_i) state_nx = IDLE;
        end else if (cnt_max) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // An edge on the same cycle the counter saturates still counts as a sample.
  always_comb begin
    arm_start   = 1'b0;
    win_open    = 1'b0;
    sample_take = 1'b0;
    cnt_inc     = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: begin
        arm_start = start_i;
      end
      ARM: begin
        if (edge_det)     win_open = 1'b1;
        else if (cnt_max) tmo      = 1'b1;
        else              cnt_inc  = 1'b1;
      end
      MEASURE: begin
        if (edge_det) begin
          if (last_sample) begin
            done     = 1'b1;
            win_open = 1'b1;
          end else begin
            sample_take = 1'b1;
          end
        end else if (cnt_max) begin
          tmo = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      n   <= '0;
    end else begin
      if (arm_start)                    cnt <= '0;
      else if (win_open || sample_take) cnt <= COUNTER_WIDTH'(1);
      else if (cnt_inc)                 cnt <= cnt + COUNTER_WIDTH'(1);

      if (win_open) begin
        acc <= '0;
        n   <= '0;
      end else if (sample_take) begin
        acc <= sum;
        n   <= n + N_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o   <= done;
      timeout_o <= tmo;
      if (done) period_o <= COUNTER_WIDTH'(sum >> AVG_LOG2);
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: three instances (single-period sync2, 4-average
// with short timeout, single-period unsynchronized) checked against a result queue.
module tb_pulse_period_meter;

  typedef struct {
    int          inst;
    bit          is_tmo;
    logic [31:0] period;
    int          cyc;
  } exp_t;

  typedef struct {
    int sp [4];
    int exp_p;
  } row_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sig;
  logic [2:0]  start;
  logic [2:0]  cont;
  logic [31:0] period [3];
  logic [2:0]  valid;
  logic [2:0]  tmo;
  logic [2:0]  busy;

  int          cyc = 0;
  int          ntests = 0;
  int          nfail = 0;
  int          last_rise = 0;
  logic [31:0] last_period [3];
  exp_t        sbq [$];
  exp_t        mon_e;
  row_t        rows [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_period_meter #(
    .AVG_LOG2    (0),
    .SYNC_STAGES (2)
  ) u_a (
    .clk (clk), .reset (reset), .sig_i (sig[0]), .start_i (start[0]), .cont_i (cont[0]),
    .period_o (period[0]), .valid_o (valid[0]), .timeout_o (tmo[0]), .busy_o (busy[0])
  );

  pulse_period_meter #(
    .AVG_LOG2    (2),
    .SYNC_STAGES (2),
    .MAX_PERIOD  (32'd100)
  ) u_b (
    .clk (clk), .reset (reset), .sig_i (sig[1]), .start_i (start[1]), .cont_i (cont[1]),
    .period_o (period[1]), .valid_o (valid[1]), .timeout_o (tmo[1]), .busy_o (busy[1])
  );

  pulse_period_meter #(
    .AVG_LOG2    (0),
    .SYNC_STAGES (0)
  ) u_c (
    .clk (clk), .reset (reset), .sig_i (sig[2]), .start_i (start[2]), .cont_i (cont[2]),
    .period_o (period[2]), .valid_o (valid[2]), .timeout_o (tmo[2]), .busy_o (busy[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sig_i rising at cycle c produces valid_o/timeout_o visible at c+SYNC+2
  function automatic int lat(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  task automatic expect_valid(input int i, input int p, input int at);
    exp_t e;
    e.inst = i; e.is_tmo = 1'b0; e.period = 32'(p); e.cyc = at;
    sbq.push_back(e);
    last_period[i] = 32'(p);
  endtask

  task automatic expect_tmo(input int i, input int at);
    exp_t e;
    e.inst = i; e.is_tmo = 1'b1; e.period = last_period[i]; e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic pulse(input int i, input int hi);
    sig[i] = 1'b1;
    last_rise = cyc;
    repeat (hi) tick;
    sig[i] = 1'b0;
  endtask

  task automatic spaced(input int i, input int s);
    repeat (s - 1) tick;
    pulse(i, 1);
  endtask

  task automatic do_start(input int i);
    start[i] = 1'b1;
    tick;
    start[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_period%0d", tag, i), period[i], 32'd0);
      check($sformatf("%s_valid%0d", tag, i), 32'(valid[i]), 32'd0);
      check($sformatf("%s_timeout%0d", tag, i), 32'(tmo[i]), 32'd0);
      check($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] || tmo[i]) begin
        if (sbq.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_output inst%0d: valid=%0d timeout=%0d period=%0d at cycle %0d, expected none",
                   i, valid[i], tmo[i], period[i], cyc);
        end else begin
          mon_e = sbq.pop_front();
          check($sformatf("out_inst%0d", i), 32'(i), 32'(mon_e.inst));
          check($sformatf("out_kind%0d", i), 32'({valid[i], tmo[i]}),
                mon_e.is_tmo ? 32'd1 : 32'd2);
          check($sformatf("out_period%0d", i), period[i], mon_e.period);
          check($sformatf("out_cycle%0d", i), 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    sig   = '0;
    start = '0;
    cont  = '0;
    for (int i = 0; i < 3; i++) last_period[i] = '0;

    rows[0] = '{sp: '{9, 10, 11, 10},     exp_p: 10};
    rows[1] = '{sp: '{12, 12, 12, 12},    exp_p: 12};
    rows[2] = '{sp: '{5, 5, 5, 6},        exp_p: 5};
    rows[3] = '{sp: '{100, 100, 100, 100}, exp_p: 100};
    rows[4] = '{sp: '{7, 8, 8, 8},        exp_p: 7};
    rows[5] = '{sp: '{2, 2, 3, 3},        exp_p: 2};

    repeat (3) tick;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) tick;

    // single period, one result then idle
    do_start(0);
    repeat (3) tick;
    pulse(0, 1);
    expect_valid(0, 10, last_rise + 10 + lat(0));
    spaced(0, 10);
    repeat (3) spaced(0, 10);
    repeat (10) tick;
    check("single_busy_after", 32'(busy[0]), 32'd0);

    // continuous averaging over the vector table
    cont[1] = 1'b1;
    do_start(1);
    repeat (2) tick;
    pulse(1, 1);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r == 5 && k == 3) cont[1] = 1'b0;
        if (k == 3) expect_valid(1, rows[r].exp_p, last_rise + rows[r].sp[k] + lat(1));
        if (r == 1 && k == 1) start[1] = 1'b1;
        spaced(1, rows[r].sp[k]);
        start[1] = 1'b0;
      end
    end
    repeat (10) tick;
    check("cont_busy_after", 32'(busy[1]), 32'd0);

    // no edge after start
    start[1] = 1'b1;
    expect_tmo(1, cyc + 102);
    tick;
    start[1] = 1'b0;
    repeat (110) tick;
    check("arm_tmo_busy", 32'(busy[1]), 32'd0);
    check("arm_tmo_period_kept", period[1], 32'd2);

    // gap of 150 in the middle of a window
    do_start(1);
    repeat (2) tick;
    pulse(1, 1);
    spaced(1, 10);
    spaced(1, 10);
    expect_tmo(1, last_rise + lat(1) + 100);
    spaced(1, 150);
    repeat (10) tick;
    check("meas_tmo_busy", 32'(busy[1]), 32'd0);
    check("meas_tmo_period_kept", period[1], 32'd2);

    // constant-high input
    sig[1] = 1'b1;
    repeat (10) tick;
    start[1] = 1'b1;
    expect_tmo(1, cyc + 102);
    tick;
    start[1] = 1'b0;
    repeat (110) tick;
    sig[1] = 1'b0;
    check("high_tmo_busy", 32'(busy[1]), 32'd0);
    repeat (5) tick;

    // reset in the middle of a window
    do_start(1);
    repeat (2) tick;
    pulse(1, 1);
    spaced(1, 20);
    spaced(1, 20);
    repeat (5) tick;
    check("pre_reset_busy", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    tick;
    check_reset_outputs("midrst");
    tick;
    check_reset_outputs("midrst2");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_period[i] = '0;
    tick;
    do_start(1);
    repeat (2) tick;
    pulse(1, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) expect_valid(1, 7, last_rise + 7 + lat(1));
      spaced(1, 7);
    end
    repeat (10) tick;

    // square wave period 4, start coincident with an edge that must be ignored
    for (int i = 0; i < 3; i += 2) begin
      int base;
      base = cyc;
      for (int t = 0; t < 30; t++) begin
        sig[i]   = (t < 2) || (t >= 6 && ((t - 6) % 4) < 2);
        start[i] = (t == lat(i) - 1);
        if (t == 0) expect_valid(i, 4, base + 10 + lat(i));
        tick;
      end
      sig[i]   = 1'b0;
      start[i] = 1'b0;
      repeat (10) tick;
      check($sformatf("square_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("square_period%0d", i), period[i], 32'd4);
    end

    repeat (20) tick;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
